// File: rtl/ap_lut_sequencer.sv
// Command-side sequencer for a bit-serial associative CAM: a compare pass
// selects rows via match tags, then a tag-guided parallel write rewrites B/carry.
module ap_lut_sequencer #(
   parameter int WORD_SIZE  = 8,
   parameter int CELL_QUANT = 512,
   parameter int OP_BITS    = 3,
   parameter int NUM_PASSES = 8,
   localparam int NP_W = $clog2(NUM_PASSES + 1),
   localparam int PA_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NP_W-1:0]       num_passes,
   input  logic                  pass_we,
   input  logic [PA_W-1:0]       pass_addr,
   input  logic [2:0]            pass_key,
   input  logic [1:0]            pass_wr,
   input  logic [CELL_QUANT-1:0] tags_in,
   output logic [WORD_SIZE-1:0]  key_out,
   output logic [WORD_SIZE-1:0]  mask_out,
   output logic [WORD_SIZE-1:0]  dina_out,
   output logic                  cam_mode_out,
   output logic [CELL_QUANT-1:0] wea_ctrl_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int BI_W = (OP_BITS > 1) ? $clog2(OP_BITS) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLR_CMP = 3'd1;
   localparam logic [2:0] S_CLR_WR  = 3'd2;
   localparam logic [2:0] S_CMP     = 3'd3;
   localparam logic [2:0] S_WR      = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [WORD_SIZE-1:0] ONE    = WORD_SIZE'(1);
   localparam logic [WORD_SIZE-1:0] CBIT   = ONE << (WORD_SIZE - 1);
   localparam logic [NP_W-1:0]      NP_MAX = NP_W'(NUM_PASSES);
   localparam logic [BI_W:0]        BI_LIM = (BI_W + 1)'(OP_BITS);

   logic [2:0]            state;
   logic [BI_W-1:0]       bit_idx;
   logic [NP_W-1:0]       pass_idx;
   logic [NP_W-1:0]       np_lat;
   logic [CELL_QUANT-1:0] tag_lat;
   logic [4:0]            tbl [NUM_PASSES];
   logic [4:0]            cur;
   logic                  last_pass;
   logic                  last_bit;

   // entry layout: {a, b, c, wr_b, wr_c}
   assign cur       = tbl[pass_idx[PA_W-1:0]];
   assign last_pass = !((pass_idx + NP_W'(1)) < np_lat);
   assign last_bit  = !(({1'b0, bit_idx} + (BI_W + 1)'(1)) < BI_LIM);

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         bit_idx  <= '0;
         pass_idx <= '0;
         np_lat   <= '0;
         tag_lat  <= '0;
         err      <= 1'b0;
         for (int k = 0; k < NUM_PASSES; k++) tbl[k] <= '0;
      end else begin
         err <= 1'b0;
         // tags only mean something while the key/mask of a compare cycle is on the bus
         if (state == S_CLR_CMP || state == S_CMP) tag_lat <= tags_in;
         case (state)
            S_IDLE: begin
               if (pass_we) tbl[pass_addr] <= {pass_key, pass_wr};
               if (start) begin
                  if (num_passes > NP_MAX) begin
                     err <= 1'b1;
                  end else begin
                     np_lat   <= num_passes;
                     bit_idx  <= '0;
                     pass_idx <= '0;
                     state    <= S_CLR_CMP;
                  end
               end
            end
            S_CLR_CMP: state <= S_CLR_WR;
            S_CLR_WR:  state <= (np_lat == '0) ? S_DONE : S_CMP;
            S_CMP:     state <= S_WR;
            S_WR: begin
               if (!last_pass) begin
                  pass_idx <= pass_idx + NP_W'(1);
                  state    <= S_CMP;
               end else if (!last_bit) begin
                  pass_idx <= '0;
                  bit_idx  <= bit_idx + BI_W'(1);
                  state    <= S_CMP;
               end else begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               bit_idx  <= '0;
               pass_idx <= '0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      key_out      = '0;
      mask_out     = '0;
      dina_out     = '0;
      cam_mode_out = 1'b0;
      wea_ctrl_out = '0;
      case (state)
         S_CLR_WR: begin
            cam_mode_out = 1'b1;
            wea_ctrl_out = tag_lat;
            mask_out     = CBIT;
         end
         S_CMP: begin
            mask_out = (ONE << bit_idx) | (ONE << (OP_BITS + int'(bit_idx))) | CBIT;
            key_out  = ({WORD_SIZE{cur[4]}} & (ONE << bit_idx))
                     | ({WORD_SIZE{cur[3]}} & (ONE << (OP_BITS + int'(bit_idx))))
                     | ({WORD_SIZE{cur[2]}} & CBIT);
         end
         S_WR: begin
            cam_mode_out = 1'b1;
            wea_ctrl_out = tag_lat;
            mask_out     = (ONE << (OP_BITS + int'(bit_idx))) | CBIT;
            dina_out     = ({WORD_SIZE{cur[1]}} & (ONE << (OP_BITS + int'(bit_idx))))
                         | ({WORD_SIZE{cur[0]}} & CBIT);
         end
         default: ;
      endcase
   end

   assign busy = (state == S_CLR_CMP) || (state == S_CLR_WR) || (state == S_CMP) || (state == S_WR);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_ap_lut_sequencer.sv
// Bench for ap_lut_sequencer: 8-row behavioural CAM, bit-serial adder vectors,
// plus hand sequences for clear-only, illegal start, disturbance and mid-run reset.
module tb_ap_lut_sequencer;

   localparam int W  = 8;
   localparam int CQ = 8;

   logic          clock = 1'b0;
   logic          rst;
   logic          start;
   logic [3:0]    num_passes;
   logic          pass_we;
   logic [2:0]    pass_addr;
   logic [2:0]    pass_key;
   logic [1:0]    pass_wr;
   logic [CQ-1:0] tags_in;
   logic [W-1:0]  key_out, mask_out, dina_out;
   logic          cam_mode_out;
   logic [CQ-1:0] wea_ctrl_out;
   logic          busy, done, err;

   ap_lut_sequencer #(.WORD_SIZE(W), .CELL_QUANT(CQ), .OP_BITS(3), .NUM_PASSES(8)) dut (
      .clock(clock), .rst(rst), .start(start), .num_passes(num_passes),
      .pass_we(pass_we), .pass_addr(pass_addr), .pass_key(pass_key), .pass_wr(pass_wr),
      .tags_in(tags_in), .key_out(key_out), .mask_out(mask_out), .dina_out(dina_out),
      .cam_mode_out(cam_mode_out), .wea_ctrl_out(wea_ctrl_out),
      .busy(busy), .done(done), .err(err));

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // behavioural CAM
   logic [W-1:0] mem    [CQ];
   logic [W-1:0] ld_vec [CQ];
   logic         ld_go = 1'b0;
   int           wr_cnt = 0;

   always_comb begin
      for (int j = 0; j < CQ; j++) tags_in[j] = (((mem[j] ^ key_out) & mask_out) == '0);
   end

   always @(posedge clock) begin
      if (ld_go) begin
         for (int j = 0; j < CQ; j++) mem[j] = ld_vec[j];
      end else if (cam_mode_out) begin
         wr_cnt++;
         for (int j = 0; j < CQ; j++)
            if (wea_ctrl_out[j]) mem[j] = (mem[j] & ~mask_out) | (dina_out & mask_out);
      end
   end

   // write enables in a write cycle must equal the tags seen in the preceding compare
   logic [CQ-1:0] cmp_tags = '0;
   logic          kd_seen  = 1'b0;
   always @(negedge clock) begin
      if (rst && busy) begin
         if (key_out != '0 || dina_out != '0) kd_seen = 1'b1;
         if (!cam_mode_out && mask_out != '0) cmp_tags = tags_in;
         if (cam_mode_out && (mask_out & 8'h38) != '0) chk("wea_latch", wea_ctrl_out, cmp_tags);
      end
   end

   typedef struct {
      logic [2:0] a, b;
      logic       cin;
      logic [2:0] eb;
      logic       ec;
   } vec_t;
   vec_t vt [CQ];

   task automatic load_rows();
      for (int j = 0; j < CQ; j++) ld_vec[j] = {vt[j].cin, 1'b0, vt[j].b, vt[j].a};
      ld_go = 1'b1;
      @(negedge clock);
      ld_go = 1'b0;
   endtask

   task automatic wr_entry(input logic [2:0] ad, input logic [2:0] k, input logic [1:0] w);
      pass_we = 1'b1; pass_addr = ad; pass_key = k; pass_wr = w;
      @(negedge clock);
      pass_we = 1'b0;
   endtask

   // start a run; counts busy cycles and reports whether done came right after busy
   task automatic run_op(input logic [3:0] np, input bit disturb, output int bc, output int dc);
      start = 1'b1; num_passes = np;
      @(negedge clock);
      start = 1'b0;
      bc = 0; dc = 0;
      for (int k = 0; k < 300; k++) begin
         if (disturb && k == 5) begin
            start = 1'b1; num_passes = 4'd1;
            pass_we = 1'b1; pass_addr = 3'd0; pass_key = 3'b111; pass_wr = 2'b00;
         end
         if (disturb && k == 6) begin start = 1'b0; pass_we = 1'b0; end
         if (done) begin
            dc = busy ? 2 : 1;
            break;
         end
         if (busy) bc++;
         @(negedge clock);
      end
      start = 1'b0; pass_we = 1'b0;
      if (dc == 0) chk("done_timeout", 0, 1);
      @(negedge clock);
   endtask

   int bc, dc, wc0;

   initial begin
      vt[0] = '{3'd3, 3'd2, 1'b1, 3'd5, 1'b0};
      vt[1] = '{3'd7, 3'd7, 1'b0, 3'd6, 1'b1};
      vt[2] = '{3'd0, 3'd0, 1'b1, 3'd0, 1'b0};
      vt[3] = '{3'd1, 3'd1, 1'b0, 3'd2, 1'b0};
      vt[4] = '{3'd5, 3'd3, 1'b1, 3'd0, 1'b1};
      vt[5] = '{3'd6, 3'd1, 1'b0, 3'd7, 1'b0};
      vt[6] = '{3'd4, 3'd4, 1'b1, 3'd0, 1'b1};
      vt[7] = '{3'd2, 3'd7, 1'b0, 3'd1, 1'b1};

      rst = 1'b0; start = 1'b0; num_passes = '0; pass_we = 1'b0;
      pass_addr = '0; pass_key = '0; pass_wr = '0;
      for (int j = 0; j < CQ; j++) begin mem[j] = '0; ld_vec[j] = '0; end
      repeat (2) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_mode", cam_mode_out, 0);
      chk("rst_wea", wea_ctrl_out, 0);
      chk("rst_kmd", {key_out, mask_out, dina_out}, 0);
      rst = 1'b1;
      @(negedge clock);

      // adder table
      wr_entry(3'd0, 3'b001, 2'b10);
      wr_entry(3'd1, 3'b011, 2'b01);
      wr_entry(3'd2, 3'b110, 2'b01);
      wr_entry(3'd3, 3'b100, 2'b10);

      load_rows();
      run_op(4'd4, 1'b0, bc, dc);
      chk("add_busy_cycles", bc, 26);
      chk("add_done_after_busy", dc, 1);
      chk("add_done_pulse", {done, busy}, 0);
      for (int j = 0; j < CQ; j++)
         chk($sformatf("add_row%0d", j), mem[j], {vt[j].ec, 1'b0, vt[j].eb, vt[j].a});

      // clear-only run
      load_rows();
      run_op(4'd0, 1'b0, bc, dc);
      chk("np0_busy_cycles", bc, 2);
      chk("np0_done_after_busy", dc, 1);
      for (int j = 0; j < CQ; j++)
         chk($sformatf("np0_row%0d", j), mem[j], {1'b0, 1'b0, vt[j].b, vt[j].a});

      // illegal pass count
      load_rows();
      wc0 = wr_cnt;
      start = 1'b1; num_passes = 4'd9;
      @(negedge clock);
      start = 1'b0;
      chk("err_pulse", {err, busy}, 2'b10);
      @(negedge clock);
      chk("err_drop", {err, busy, done}, 0);
      repeat (3) @(negedge clock);
      chk("err_no_writes", wr_cnt - wc0, 0);
      chk("err_row0", mem[0], {vt[0].cin, 1'b0, vt[0].b, vt[0].a});

      // start/pass_we during busy must be ignored
      load_rows();
      run_op(4'd4, 1'b1, bc, dc);
      chk("dist_busy_cycles", bc, 26);
      for (int j = 0; j < CQ; j++)
         chk($sformatf("dist_row%0d", j), mem[j], {vt[j].ec, 1'b0, vt[j].eb, vt[j].a});

      // asynchronous reset in the first write cycle
      load_rows();
      start = 1'b1; num_passes = 4'd4;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      chk("mid_in_wr", {cam_mode_out, busy, mask_out[3]}, 3'b111);
      rst = 1'b0;
      #1;
      chk("mid_wea", wea_ctrl_out, 0);
      chk("mid_mode", cam_mode_out, 0);
      chk("mid_busy_done", {busy, done}, 0);
      chk("mid_kmd", {key_out, mask_out, dina_out}, 0);
      #2 rst = 1'b1;
      @(negedge clock);
      chk("mid_no_done", done, 0);

      // cleared table: every key/data field stays zero on the next run
      load_rows();
      kd_seen = 1'b0;
      run_op(4'd2, 1'b0, bc, dc);
      chk("tbl_cleared", kd_seen, 0);
      chk("tbl_busy_cycles", bc, 14);
      for (int j = 0; j < CQ; j++)
         chk($sformatf("tbl_row%0d", j), mem[j], {1'b0, 1'b0, vt[j].b, vt[j].a});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
